// File: rtl/mem_access_ctrl_pkg.sv
// Shared pipeline package for the memory-stage access controller.
// Holds the FSM state encoding, the default access latency, bus widths
// and the registered-request record used by mem_access_ctrl.
package mem_access_ctrl_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int DEFAULT_LATENCY = 4;
  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W           = 4;

  // FSM encoding is kept as plain 2-bit constants so that legacy blocks
  // which compare raw state bits continue to line up.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  // Request as captured in the acceptance cycle.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage : mem_access_ctrl_pkg

// File: rtl/mem_access_ctrl_if.sv
// Pipeline/memory bus bundle for mem_access_ctrl.
// slave  : the controller (takes requests, drives the memory port).
// master : the surrounding pipeline + memory model.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  // Pipeline side
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              halt;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  // Memory side
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              createdump;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, halt, mem_rdata,
    output stall, done, rdata, err,
    output mem_en, mem_wr, mem_addr, mem_wdata, createdump
  );

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, halt, mem_rdata,
    input  stall, done, rdata, err,
    input  mem_en, mem_wr, mem_addr, mem_wdata, createdump
  );

endinterface : mem_access_ctrl_if

// File: rtl/mem_lat_counter.sv
// Memory-latency down-counter: loads a start value, counts down by one
// while enabled and flags zero. Saturates at zero.
module mem_lat_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over decrement; count never wraps below zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule : mem_lat_counter

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns single-cycle read/write requests
// from the pipeline into a LATENCY-cycle memory access, stalling upstream
// stages until a one-cycle done pulse.
// Optional feature: define MEM_ACCESS_ALIGN_EN to reject odd byte
// addresses with a one-cycle err+done pulse and no memory access.
// LATENCY legal range: 1..15.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next_state;
  req_t              r_req;
  logic [DATA_W-1:0] r_rdata;

  logic w_idle;
  logic w_busy;
  logic w_accept;
  logic w_misaligned;
  logic w_cnt_zero;

  assign w_idle   = (r_state == IDLE);
  assign w_busy   = (r_state == BUSY);
  // Write wins when both request strobes are high (handled by r_req.wr).
  assign w_accept = w_idle & (bus.req_rd | bus.req_wr) & ~bus.halt;

`ifdef MEM_ACCESS_ALIGN_EN
  logic r_err;

  assign w_misaligned = bus.req_addr[0];

  // Remember whether the accepted request was rejected for alignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misaligned;
    end
  end

  assign bus.err = (r_state == DONE) & r_err;
`else
  assign w_misaligned = 1'b0;
  assign bus.err      = 1'b0;
`endif

  // Latency counter: loaded on an aligned acceptance, counts BUSY cycles.
  mem_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept & ~w_misaligned),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_busy),
    .o_zero     (w_cnt_zero)
  );

  // Next-state logic for IDLE -> BUSY -> DONE -> IDLE.
  // NOTE: the default assignment at the top keeps this purely
  // combinational; without it a missed branch would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_misaligned ? DONE : BUSY;
      BUSY:    if (w_cnt_zero) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the request in the acceptance cycle; held through BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.wr    <= bus.req_wr;
      r_req.addr  <= bus.req_addr;
      r_req.wdata <= bus.req_wdata;
    end
  end

  // Read data is latched on the last BUSY cycle of a read only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_busy && w_cnt_zero && !r_req.wr) begin
      r_rdata <= bus.mem_rdata;
    end
  end

  // Memory port: driven from registered values, enabled only in BUSY.
  assign bus.mem_en    = w_busy;
  assign bus.mem_wr    = w_busy & r_req.wr;
  assign bus.mem_addr  = r_req.addr;
  assign bus.mem_wdata = r_req.wdata;

  // Pipeline outputs. stall and createdump depend on live inputs, so they
  // are also qualified by rst to read 0 the instant reset asserts.
  assign bus.stall      = rst & (w_accept | w_busy);
  assign bus.done       = (r_state == DONE);
  assign bus.rdata      = r_rdata;
  assign bus.createdump = rst & bus.halt & w_idle;

endmodule : mem_access_ctrl
